// File: rtl/sel_ctrl_pkg.sv
// Shared constants and helpers for the selector control stage.
// Hardware defaults, small simulation overrides, and counter sizing.
package sel_ctrl_pkg;

  localparam int unsigned DefDebounceCycles = 250000;
  localparam int unsigned DefAutoPeriod     = 50000000;

  localparam int unsigned SimDebounceCycles = 4;
  localparam int unsigned SimAutoPeriod     = 8;

  // Bits needed to hold values 0 .. n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus mismatch-count debouncer for a raw pushbutton.
// RISE is combinational and coincides with the edge that updates LEVEL.
module btn_debounce
  import sel_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic IN,
  output logic LEVEL,
  output logic RISE
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            mismatch;
  logic            accept;

  always_comb begin
    cnt_inc  = cnt_q + CntW'(1);
    mismatch = (sync2_q != level_q);
    accept   = mismatch && (cnt_inc == CntMax);
    level_d  = level_q;
    cnt_d    = '0;
    // Any agreeing cycle leaves cnt_d at zero, so a glitch restarts the count.
    if (mismatch) begin
      if (accept) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= IN;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign LEVEL = level_q;
  assign RISE  = accept & sync2_q;

endmodule

// File: rtl/sel_toggle_ctrl.sv
// Select generator for the 2:1 data selector: debounced presses toggle SEL,
// and auto mode toggles it every AUTO_PERIOD cycles.
module sel_toggle_ctrl
  import sel_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned AUTO_PERIOD     = DefAutoPeriod
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  input  logic AUTO,
  output logic SEL,
  output logic PRESS
);

  localparam int unsigned AutoW = cnt_width(AUTO_PERIOD);
  localparam logic [AutoW-1:0] AutoLast = AutoW'(AUTO_PERIOD - 1);

  logic             btn_level;
  logic             btn_rise;
  logic             unused_btn_level;
  logic             auto_sync1_q;
  logic             auto_s_q;
  logic [AutoW-1:0] cnt_a_q, cnt_a_d;
  logic             sel_q, sel_d;
  logic             press_q, press_d;
  logic             auto_tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK  (CLK),
    .RST_N(RST_N),
    .IN   (BTN),
    .LEVEL(btn_level),
    .RISE (btn_rise)
  );

  assign unused_btn_level = btn_level;

  always_comb begin
    auto_tick = auto_s_q && (cnt_a_q == AutoLast);
    cnt_a_d   = '0;
    // A press or a tick restarts the period; a coincident pair toggles once.
    if (auto_s_q && !btn_rise && !auto_tick) begin
      cnt_a_d = cnt_a_q + AutoW'(1);
    end
    sel_d   = sel_q ^ (btn_rise | auto_tick);
    press_d = btn_rise;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      auto_sync1_q <= 1'b0;
      auto_s_q     <= 1'b0;
      cnt_a_q      <= '0;
      sel_q        <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      auto_sync1_q <= AUTO;
      auto_s_q     <= auto_sync1_q;
      cnt_a_q      <= cnt_a_d;
      sel_q        <= sel_d;
      press_q      <= press_d;
    end
  end

  assign SEL   = sel_q;
  assign PRESS = press_q;

`ifndef SYNTHESIS
  // Every PRESS pulse must be accompanied by a SEL toggle on the same edge.
  press_toggles_sel: assert property (@(posedge CLK) disable iff (!RST_N)
    PRESS |-> (SEL != $past(SEL)));
`endif

endmodule

// File: tb/tb_sel_toggle_ctrl.sv
// Scenario bench for sel_toggle_ctrl with small debounce and auto periods.
module tb_sel_toggle_ctrl;
  import sel_ctrl_pkg::*;

  typedef struct {
    logic sel;
    logic press;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  logic auto_sw = 1'b0;
  logic sel;
  logic press;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  sel_toggle_ctrl #(
    .DEBOUNCE_CYCLES(SimDebounceCycles),
    .AUTO_PERIOD    (SimAutoPeriod)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .BTN  (btn),
    .AUTO (auto_sw),
    .SEL  (sel),
    .PRESS(press)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    btn     = 1'b0;
    auto_sw = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Reset with BTN and AUTO high, then a press that restarts the auto period.
  task automatic test_reset();
    exp_t e;
    rst_n   = 1'b0;
    btn     = 1'b1;
    auto_sw = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      sb_q.push_back('{sel: 1'b0, press: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL reset_hold edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      sb_q.push_back('{sel: (n >= 6 && n < 14), press: (n == 6)});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL reset_release edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
  endtask

  task automatic test_clean_press();
    exp_t e;
    apply_reset();
    for (int ph = 0; ph < 4; ph++) begin
      btn = (ph == 0 || ph == 2);
      for (int n = 1; n <= 10; n++) begin
        case (ph)
          0:       sb_q.push_back('{sel: (n >= 6), press: (n == 6)});
          1:       sb_q.push_back('{sel: 1'b1, press: 1'b0});
          2:       sb_q.push_back('{sel: (n < 6), press: (n == 6)});
          default: sb_q.push_back('{sel: 1'b0, press: 1'b0});
        endcase
        tick();
        e = sb_q.pop_front();
        checks++;
        if (sel !== e.sel || press !== e.press) begin
          errors++;
          $display("FAIL clean_press phase %0d edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                   ph, n, sel, press, e.sel, e.press);
        end
      end
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    apply_reset();
    for (int n = 1; n <= 30; n++) begin
      btn = (n <= 20) && (((n - 1) % 4) < 3);
      sb_q.push_back('{sel: 1'b0, press: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL bounce edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
  endtask

  // auto_s reads 1 at edge 2 and 0 at edge 42, so ticks land on 10,18,26,34,42.
  task automatic test_auto();
    exp_t e;
    int   tog = 0;
    apply_reset();
    for (int n = 1; n <= 60; n++) begin
      auto_sw = (n <= 40);
      if (n >= 10 && n <= 42 && ((n - 10) % 8) == 0) tog++;
      sb_q.push_back('{sel: tog[0], press: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL auto edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
  endtask

  // Press accepted at edge 10, the same edge as the first auto tick.
  task automatic test_collision();
    exp_t e;
    apply_reset();
    auto_sw = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      btn = (n >= 5);
      sb_q.push_back('{sel: ((n >= 10 && n < 18) || n >= 26), press: (n == 10)});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL collision edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
  endtask

  // Reset lands with cnt_d = 3 and cnt_a = 5; afterwards both restart from zero.
  task automatic test_mid_reset();
    exp_t e;
    apply_reset();
    auto_sw = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      btn   = (n >= 3);
      rst_n = (n <= 7);
      sb_q.push_back('{sel: 1'b0, press: 1'b0});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL mid_reset_pre edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      btn = (n >= 11);
      sb_q.push_back('{sel: ((n >= 10 && n < 16) || n >= 24), press: (n == 16)});
      tick();
      e = sb_q.pop_front();
      checks++;
      if (sel !== e.sel || press !== e.press) begin
        errors++;
        $display("FAIL mid_reset_post edge %0d: got sel=%b press=%b, want sel=%b press=%b",
                 n, sel, press, e.sel, e.press);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto();
    test_collision();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, want completion");
    $fatal(1, "time limit");
  end

endmodule
